// File: rtl/div_sched_if.sv
// div_sched_if: requester and response handshake bundle for div_sched.
//   req0_* / req1_* : valid/ready operand ports for the two requesters
//                     (a = dividend, b = divisor)
//   resp_*          : valid/ready result port (id, quotient, remainder,
//                     divide-by-zero flag)
// The master modport is the client side; the slave modport is the divider.
interface div_sched_if #(
   parameter int unsigned W = 6
);
   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         resp_valid;
   logic         resp_ready;
   logic         resp_id;
   logic [W-1:0] resp_q;
   logic [W-1:0] resp_r;
   logic         resp_dz;

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
      input  req0_ready, req1_ready, resp_valid, resp_id, resp_q, resp_r, resp_dz
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
      output req0_ready, req1_ready, resp_valid, resp_id, resp_q, resp_r, resp_dz
   );
endinterface

// File: rtl/div_sched.sv
// div_sched: round-robin arbitrated, shared multi-cycle unsigned divider.
// One restoring shift-subtract step per clock, quotient MSB first.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : div_sched_if.slave -- two requester ports (valid/ready, a, b)
//           and one response port (valid/ready, id, q, r, dz)
module div_sched #(
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   div_sched_if.slave   bus
);
   localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic           r_last_grant;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_q;
   // remainder is always < b after a step, so its top bit is never set;
   // only the low W bits are kept and the shift-in bit extends t instead
   logic [W-1:0]   r_rem;
   logic [IW-1:0]  r_idx;
   logic           r_id;
   logic           r_resp_id;
   logic           r_resp_dz;
   logic [W-1:0]   r_resp_q;
   logic [W-1:0]   r_resp_r;

   logic           w_grant0;
   logic           w_grant1;
   logic           w_acc;
   logic           w_acc_id;
   logic [W-1:0]   w_acc_a;
   logic [W-1:0]   w_acc_b;
   logic [W:0]     w_t;
   logic           w_ge;
   logic [W-1:0]   w_rem_nxt;
   logic [W-1:0]   w_q_nxt;
   logic           w_last_step;

   // grant: a lone requester always wins; on a tie the one not granted last
   always_comb begin
      w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
      w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
      w_acc    = (r_state == S_IDLE) && (w_grant0 || w_grant1);
      w_acc_id = w_grant1;
      w_acc_a  = w_grant1 ? bus.req1_a : bus.req0_a;
      w_acc_b  = w_grant1 ? bus.req1_b : bus.req0_b;
   end

   always_comb begin
      w_t         = {r_rem, r_a[r_idx]};
      w_ge        = (w_t >= {1'b0, r_b});
      w_rem_nxt   = w_ge ? W'(w_t - {1'b0, r_b}) : w_t[W-1:0];
      w_q_nxt     = r_q;
      w_q_nxt[r_idx] = w_ge;
      w_last_step = (r_idx == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_acc) w_next = (w_acc_b == '0) ? S_DONE : S_CALC;
         S_CALC: if (w_last_step) w_next = S_DONE;
         S_DONE: if (bus.resp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_a          <= '0;
         r_b          <= '0;
         r_q          <= '0;
         r_rem        <= '0;
         r_idx        <= '0;
         r_id         <= 1'b0;
         r_resp_id    <= 1'b0;
         r_resp_dz    <= 1'b0;
         r_resp_q     <= '0;
         r_resp_r     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  r_a          <= w_acc_a;
                  r_b          <= w_acc_b;
                  r_id         <= w_acc_id;
                  r_last_grant <= w_acc_id;
                  r_rem        <= '0;
                  r_q          <= '0;
                  r_idx        <= IW'(W - 1);
                  // divide by zero skips CALC, so the result is loaded here
                  if (w_acc_b == '0) begin
                     r_resp_q  <= '1;
                     r_resp_r  <= w_acc_a;
                     r_resp_dz <= 1'b1;
                     r_resp_id <= w_acc_id;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_rem_nxt;
               r_q   <= w_q_nxt;
               r_idx <= r_idx - IW'(1);
               if (w_last_step) begin
                  r_resp_q  <= w_q_nxt;
                  r_resp_r  <= w_rem_nxt;
                  r_resp_dz <= 1'b0;
                  r_resp_id <= r_id;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.req0_ready = rst_n && (r_state == S_IDLE) && w_grant0;
      bus.req1_ready = rst_n && (r_state == S_IDLE) && w_grant1;
      bus.resp_valid = (r_state == S_DONE);
      bus.resp_id    = r_resp_id;
      bus.resp_q     = r_resp_q;
      bus.resp_r     = r_resp_r;
      bus.resp_dz    = r_resp_dz;
   end
endmodule
